// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: FIFO-backed UART echo engine.
//
// Each byte from the receiver is acknowledged and pushed into a DEPTH-entry FIFO.
// If the FIFO is full, the byte is dropped instead and counted. Queued bytes are
// XORed with XOR_MASK and re-sent one at a time under a tx_start/tx_busy handshake.
//
// Build option: define UART_ECHO_CRLF_EN to append a LF after every echoed CR (0x0D).
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   en              allows new transmissions to launch (intake always runs)
//   rx_readable     receiver holds a byte; rx_data is that byte
//   rx_used_tick    one-cycle acknowledge back to the receiver
//   tx_start        one-cycle launch pulse; tx_data is the byte to send
//   tx_busy         transmitter busy
//   fifo_level      FIFO occupancy, 0..DEPTH
//   overflow        sticky drop flag
//   drop_count      saturating count of dropped bytes
//   clr_ovf         synchronous clear of overflow and drop_count
module uart_echo_buffer #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 16,
    parameter logic [DATA_W-1:0] XOR_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       rx_readable,
    input  logic [DATA_W-1:0]          rx_data,
    output logic                       rx_used_tick,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    input  logic                       clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {IIdle, IAck, IWait} i_state_e;
    typedef enum logic [2:0] {
        TIdle, TStart, TAckw, TBusy
`ifdef UART_ECHO_CRLF_EN
        , TLf
`endif
    } t_state_e;

    i_state_e          i_state;
    t_state_e          t_state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] head;
    logic              full;
    logic              push;
    logic              drop;
    logic              pop;

`ifdef UART_ECHO_CRLF_EN
    localparam logic [DATA_W-1:0] CrChar = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] LfChar = DATA_W'(8'h0A);
    logic lf_pending;
`endif

    // Full/empty decisions use the pre-edge level, so a push while full is dropped
    // even when a pop happens on the same edge.
    assign full = (fifo_level == LW'(DEPTH));
    assign push = (i_state == IIdle) && rx_readable && !full;
    assign drop = (i_state == IIdle) && rx_readable && full;
    assign pop  = (t_state == TIdle) && en && (fifo_level != '0) && !tx_busy;
    assign head = mem[rd_ptr];

    // Intake FSM: capture once per rx_readable assertion, then wait for it to clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_state      <= IIdle;
            rx_used_tick <= 1'b0;
        end else begin
            unique case (i_state)
                IIdle: begin
                    if (rx_readable) begin
                        i_state      <= IAck;
                        rx_used_tick <= 1'b1;
                    end
                end
                IAck: begin
                    rx_used_tick <= 1'b0;
                    i_state      <= IWait;
                end
                IWait: begin
                    if (!rx_readable) begin
                        i_state <= IIdle;
                    end
                end
                default: begin
                    i_state      <= IIdle;
                    rx_used_tick <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // A drop on the same edge as clr_ovf wins and restarts the count at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

    // Transmit FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_state    <= TIdle;
            tx_start   <= 1'b0;
            tx_data    <= '0;
`ifdef UART_ECHO_CRLF_EN
            lf_pending <= 1'b0;
`endif
        end else begin
            unique case (t_state)
                TIdle: begin
                    if (pop) begin
                        tx_data    <= head ^ XOR_MASK;
                        tx_start   <= 1'b1;
                        t_state    <= TStart;
`ifdef UART_ECHO_CRLF_EN
                        lf_pending <= (head == CrChar);
`endif
                    end
                end
                TStart: begin
                    tx_start <= 1'b0;
                    t_state  <= TAckw;
                end
                TAckw: begin
                    if (tx_busy) begin
                        t_state <= TBusy;
                    end
                end
                TBusy: begin
                    if (!tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
                        t_state <= lf_pending ? TLf : TIdle;
`else
                        t_state <= TIdle;
`endif
                    end
                end
`ifdef UART_ECHO_CRLF_EN
                // The LF belongs to the CR just sent, so en does not gate it.
                TLf: begin
                    tx_data    <= LfChar ^ XOR_MASK;
                    tx_start   <= 1'b1;
                    lf_pending <= 1'b0;
                    t_state    <= TStart;
                end
`endif
                default: begin
                    t_state  <= TIdle;
                    tx_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer (DEPTH=16). A second instance with
// XOR_MASK=0x20 shares all inputs so masked output can be compared side by side.
module tb_uart_echo_buffer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx_readable;
    logic [7:0] rx_data;
    logic       rx_used_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [4:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clr_ovf;

    logic       x_rx_used_tick;
    logic       x_tx_start;
    logic [7:0] x_tx_data;
    logic [4:0] x_fifo_level;
    logic       x_overflow;
    logic [7:0] x_drop_count;

    int tests = 0;
    int fails = 0;

    int         busy_len = 10;
    int         bcnt;
    int         start_cnt = 0;
    int         tick_cnt = 0;
    logic [7:0] tx_log [$];
    logic [7:0] txx_log [$];

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .XOR_MASK(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_readable(rx_readable), .rx_data(rx_data),
        .rx_used_tick(rx_used_tick), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .fifo_level(fifo_level), .overflow(overflow),
        .drop_count(drop_count), .clr_ovf(clr_ovf)
    );

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .XOR_MASK(8'h20)) dut_x (
        .clk(clk), .rst(rst), .en(en), .rx_readable(rx_readable), .rx_data(rx_data),
        .rx_used_tick(x_rx_used_tick), .tx_start(x_tx_start), .tx_data(x_tx_data),
        .tx_busy(tx_busy), .fifo_level(x_fifo_level), .overflow(x_overflow),
        .drop_count(x_drop_count), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting one cycle after tx_start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            bcnt    <= 0;
            tx_busy <= 1'b0;
        end
    end

    // Monitor: log launched bytes and count acknowledges.
    always @(posedge clk) begin
        if (rst) begin
            if (tx_start) begin
                tx_log.push_back(tx_data);
                start_cnt <= start_cnt + 1;
            end
            if (x_tx_start) txx_log.push_back(x_tx_data);
            if (rx_used_tick) tick_cnt <= tick_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: hold the byte until acknowledged, then let the intake FSM rearm.
    task automatic send_byte(input logic [7:0] b);
        int k;
        logic got;
        got = 1'b0;
        rx_data = b;
        rx_readable = 1'b1;
        for (k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = rx_used_tick;
        end
        if (!got) check("rx_ack_timeout", {31'd0, got}, 32'd1);
        rx_readable = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k;
        k = 0;
        while (start_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("start_count", start_cnt, target);
    endtask

    initial begin
        int base;
        int tbase;
        rst = 1'b0;
        en = 1'b1;
        rx_readable = 1'b0;
        rx_data = 8'h00;
        clr_ovf = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tick", rx_used_tick, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drops", drop_count, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: ack and level in N+1, start and data in N+2
        rx_data = 8'h41;
        rx_readable = 1'b1;
        @(negedge clk);
        check("t1_tick", rx_used_tick, 1);
        check("t1_level", fifo_level, 1);
        check("t1_nostart", tx_start, 0);
        rx_readable = 1'b0;
        @(negedge clk);
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'h41);
        check("t1_xdata", x_tx_data, 8'h61);
        check("t1_level0", fifo_level, 0);
        check("t1_tick0", rx_used_tick, 0);
        repeat (20) @(negedge clk);
        check("t1_ticks", tick_cnt, 1);
        check("t1_starts", start_cnt, 1);

        // Long rx_readable: exactly one capture; mask applied in dut_x
        rx_data = 8'h61;
        rx_readable = 1'b1;
        repeat (5) @(negedge clk);
        rx_readable = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_ticks", tick_cnt, 2);
        wait_starts(2, 20);
        repeat (20) @(negedge clk);
        check("t2_starts", start_cnt, 2);
        check("t2_data", tx_log[1], 8'h61);
        check("t2_xdata", txx_log[1], 8'h41);

        // en=0 holds bytes in the FIFO; raising it sends them in order
        en = 1'b0;
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        repeat (5) @(negedge clk);
        check("t3_level", fifo_level, 3);
        check("t3_nostart", start_cnt, 2);
        en = 1'b1;
        wait_starts(5, 100);
        repeat (20) @(negedge clk);
        check("t3_b0", tx_log[2], 8'hA1);
        check("t3_b1", tx_log[3], 8'hA2);
        check("t3_b2", tx_log[4], 8'hA3);
        check("t3_level0", fifo_level, 0);

        // Overflow stream: 20 bytes every 3 cycles vs one byte per 43 cycles.
        // Levels peak at 16 before byte 18, so bytes 0x12 and 0x13 are dropped.
        busy_len = 40;
        base = start_cnt;
        for (int k = 0; k < 20; k++) begin
            if (k == 18) begin
                check("t4_full", fifo_level, 16);
                check("t4_noovf", overflow, 0);
            end
            send_byte(8'(k));
        end
        check("t4_ovf", overflow, 1);
        check("t4_drops", drop_count, 2);
        wait_starts(base + 18, 18 * 43 + 100);
        repeat (60) @(negedge clk);
        check("t4_total", start_cnt, base + 18);
        for (int k = 0; k < 18; k++) begin
            check("t4_order", tx_log[base + k], k);
        end

        // clr_ovf alone clears; clr_ovf with a drop gives overflow=1, drop_count=1
        busy_len = 10;
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t5_clr_ovf", overflow, 0);
        check("t5_clr_cnt", drop_count, 0);
        en = 1'b0;
        for (int k = 0; k < 16; k++) send_byte(8'h30 + 8'(k));
        check("t5_full", fifo_level, 16);
        rx_data = 8'hEE;
        rx_readable = 1'b1;
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t5_ovf", overflow, 1);
        check("t5_cnt", drop_count, 1);
        rx_readable = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_cnt_hold", drop_count, 1);

        // Reset mid-transmission with bytes queued
        base = start_cnt;
        en = 1'b1;
        wait_starts(base + 1, 20);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_level", fifo_level, 0);
        check("t6_start", tx_start, 0);
        check("t6_data", tx_data, 0);
        check("t6_tick", rx_used_tick, 0);
        check("t6_ovf", overflow, 0);
        check("t6_drops", drop_count, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_nostale", start_cnt, base + 1);
        check("t6_level_after", fifo_level, 0);

        // CR handling
        base = start_cnt;
        tbase = txx_log.size();
        send_byte(8'h0D);
        send_byte(8'h42);
`ifdef UART_ECHO_CRLF_EN
        wait_starts(base + 3, 100);
        repeat (20) @(negedge clk);
        check("t7_cr", tx_log[base], 8'h0D);
        check("t7_lf", tx_log[base + 1], 8'h0A);
        check("t7_b", tx_log[base + 2], 8'h42);
        check("t7_xlf", txx_log[tbase + 1], 8'h2A);
        check("t7_total", start_cnt, base + 3);
`else
        wait_starts(base + 2, 100);
        repeat (20) @(negedge clk);
        check("t7_cr", tx_log[base], 8'h0D);
        check("t7_b", tx_log[base + 1], 8'h42);
        check("t7_xb", txx_log[tbase + 1], 8'h62);
        check("t7_total", start_cnt, base + 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
